// File: rtl/uart_rx_ctrl_if.sv
// Pop port of the UART receive FIFO.
// valid/ready: the head entry transfers on a clk edge where out_valid && out_ready are both 1;
// out_data/out_perr are stable while out_valid is high and not popped; out_ready may be held high freely.
interface uart_rx_ctrl_if;
  logic [7:0] out_data;
  logic       out_perr;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_perr,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_perr,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: line synchroniser, start detect, mid-bit rx_en strobes,
// frame-end/timeout tracking and a small receive FIFO with sticky error flags.
module uart_rx_ctrl #(
  parameter int CLK_DIV     = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_TICKS = 11
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          rx_in,
  output logic                          rx_sync,
  output logic                          rx_en,
  input  logic                          rx_busy,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_perr,
  uart_rx_ctrl_if.master                pop,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overrun,
  output logic                          frame_err,
  input  logic                          clr_err,
  output logic [1:0]                    state_dbg
);

  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int TICK_W = $clog2(FRAME_TICKS + 2);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CW     = PTR_W + 1;

  localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_TICKS);
  localparam logic [CW-1:0]     FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    FRAME = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [TICK_W-1:0]   ticks, ticks_n;
  logic                sync1, sync2, sync3;
  logic                busy_q;
  logic                line_fall, busy_fall;
  logic                push, ferr_set;

  // Synchroniser flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync3  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      sync1  <= rx_in;
      sync2  <= sync1;
      sync3  <= sync2;
      busy_q <= rx_busy;
    end
  end

  assign rx_sync   = sync2;
  assign line_fall = sync3 & ~sync2;
  assign busy_fall = busy_q & ~rx_busy;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      cnt   <= '0;
      ticks <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ticks <= ticks_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ticks_n  = ticks;
    rx_en    = 1'b0;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        if (line_fall) begin
          cnt_n   = HALF_LOAD;
          state_n = START;
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else if (!rx_sync) begin
          rx_en   = 1'b1;
          cnt_n   = FULL_LOAD;
          ticks_n = TICK_W'(1);
          state_n = FRAME;
        end else begin
          state_n = IDLE;
        end
      end
      FRAME: begin
        // Frame end outranks a bit tick landing in the same cycle.
        if (busy_fall) begin
          state_n = DRAIN;
        end else if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          rx_en   = 1'b1;
          cnt_n   = FULL_LOAD;
          ticks_n = ticks + TICK_W'(1);
          if (ticks == TICK_LAST) begin
            ferr_set = 1'b1;
            state_n  = IDLE;
          end
        end
      end
      DRAIN: begin
        push    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [8:0]       head;
  logic             do_pop, do_push, ovr_set;

  assign do_pop  = pop.out_valid & pop.out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & ((count != FULL_CNT) | do_pop);
  assign ovr_set = push & (count == FULL_CNT) & ~do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {rx_perr, rx_data};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head          = mem[rd_ptr];
  assign pop.out_valid = (count != '0);
  assign pop.out_data  = pop.out_valid ? head[7:0] : 8'h00;
  assign pop.out_perr  = pop.out_valid ? head[8] : 1'b0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (ferr_set)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: serial frames on rx_in, a small shift-receiver model on
// rx_en/rx_sync, and an expected-byte queue for the FIFO output.
module tb_uart_rx_ctrl;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       rx_in = 1'b1;
  logic       clr_err = 1'b0;
  logic       rx_sync, rx_en, rx_busy, rx_perr;
  logic [7:0] rx_data;
  logic [2:0] count;
  logic       overrun, frame_err;
  logic [1:0] state_dbg;

  uart_rx_ctrl_if pop_if ();

  uart_rx_ctrl #(.CLK_DIV(16), .FIFO_DEPTH(4), .FRAME_TICKS(11)) dut (
    .clk(clk), .resetN(resetN), .rx_in(rx_in), .rx_sync(rx_sync), .rx_en(rx_en),
    .rx_busy(rx_busy), .rx_data(rx_data), .rx_perr(rx_perr), .pop(pop_if),
    .count(count), .overrun(overrun), .frame_err(frame_err), .clr_err(clr_err),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // shift-receiver model: start, 8 data bits LSB first, even parity, stop
  logic       force_busy = 1'b0;
  logic       busy_r, perr_r;
  logic [7:0] sh;
  int         n;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      busy_r <= 1'b0; perr_r <= 1'b0; sh <= 8'h00; n <= 0;
    end else if (rx_en && !force_busy) begin
      if (!busy_r) begin
        busy_r <= 1'b1; n <= 0;
      end else begin
        if (n < 8)       sh <= {rx_sync, sh[7:1]};
        else if (n == 8) perr_r <= (^sh) ^ rx_sync;
        else             busy_r <= 1'b0;
        n <= n + 1;
      end
    end
  end
  assign rx_busy = force_busy | busy_r;
  assign rx_data = sh;
  assign rx_perr = perr_r;

  // strobe / edge log
  int   cyc = 0;
  int   en_q[$];
  int   fall_q[$];
  logic sync_prev = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    sync_prev <= rx_sync;
    if (sync_prev && !rx_sync) fall_q.push_back(cyc);
    if (rx_en) en_q.push_back(cyc);
  end

  // scoreboard
  logic [8:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    logic [10:0] bits;
    bits = {1'b1, (^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_in = bits[i];
      repeat (16) @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_one(input string tag);
    logic [8:0] e;
    check({tag, "_valid"}, pop_if.out_valid, 1'b1);
    if (exp_q.size() == 0) begin
      check({tag, "_exp_avail"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, pop_if.out_data, e[7:0]);
      check({tag, "_perr"}, pop_if.out_perr, e[8]);
    end
    pop_if.out_ready = 1'b1;
    @(negedge clk);
    pop_if.out_ready = 1'b0;
  endtask

  task automatic check_strobes(input string tag, input int e0, input int f0, input int exp_n);
    int bad_gaps;
    check({tag, "_en_cnt"}, en_q.size() - e0, exp_n);
    if (en_q.size() > e0 && fall_q.size() > f0) begin
      check({tag, "_first_en"}, en_q[e0] - fall_q[f0], 8);
      bad_gaps = 0;
      for (int i = e0 + 1; i < en_q.size(); i++)
        if (en_q[i] - en_q[i-1] != 16) bad_gaps++;
      check({tag, "_gaps"}, bad_gaps, 0);
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic pop_on_drain();
    logic [8:0] e;
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (state_dbg == S_DRAIN) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        check("drain_pop_data", pop_if.out_data, e[7:0]);
        pop_if.out_ready = 1'b1;
        @(negedge clk);
        pop_if.out_ready = 1'b0;
      end
    end
    check("drain_seen", seen, 1'b1);
  endtask

  initial begin
    int e0, f0;
    logic [7:0] five [5];
    five[0] = 8'h11; five[1] = 8'h22; five[2] = 8'h33; five[3] = 8'h44; five[4] = 8'h5A;
    pop_if.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_state", state_dbg, S_IDLE);
    check("rst_rx_sync", rx_sync, 1'b1);
    check("rst_rx_en", rx_en, 1'b0);
    check("rst_valid", pop_if.out_valid, 1'b0);
    check("rst_count", count, 0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_data", pop_if.out_data, 8'h00);
    check("rst_perr", pop_if.out_perr, 1'b0);
    resetN = 1'b1;
    repeat (5) @(negedge clk);

    // good frame 0x55
    e0 = en_q.size(); f0 = fall_q.size();
    send_frame(8'h55, 1'b0);
    exp_q.push_back({1'b0, 8'h55});
    check_strobes("f55", e0, f0, 11);
    check("f55_count", count, 1);
    check("f55_state", state_dbg, S_IDLE);
    pop_one("f55");
    check("f55_count_after_pop", count, 0);

    // parity error frame
    send_frame(8'hA3, 1'b1);
    exp_q.push_back({1'b1, 8'hA3});
    check("fa3_count", count, 1);
    pop_one("fa3");

    // 3-clk glitch
    e0 = en_q.size(); f0 = fall_q.size();
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_fall_seen", fall_q.size() - f0, 1);
    check("glitch_en_cnt", en_q.size() - e0, 0);
    check("glitch_count", count, 0);
    check("glitch_state", state_dbg, S_IDLE);

    // frame timeout with busy stuck high
    force_busy = 1'b1;
    e0 = en_q.size(); f0 = fall_q.size();
    send_frame(8'h00, 1'b0);
    repeat (30) @(negedge clk);
    check_strobes("tmo", e0, f0, 12);
    check("tmo_frame_err", frame_err, 1'b1);
    check("tmo_state", state_dbg, S_IDLE);
    check("tmo_count", count, 0);
    force_busy = 1'b0;
    repeat (2) @(negedge clk);
    pulse_clr();
    check("tmo_clr", frame_err, 1'b0);

    // overrun: five frames into a 4-entry FIFO
    for (int i = 0; i < 5; i++) begin
      send_frame(five[i], 1'b0);
      if (i < 4) exp_q.push_back({1'b0, five[i]});
    end
    check("ovr_count", count, 4);
    check("ovr_flag", overrun, 1'b1);
    for (int i = 0; i < 4; i++) pop_one("ovr_pop");
    check("ovr_empty", count, 0);
    check("ovr_flag_held", overrun, 1'b1);
    pulse_clr();
    check("ovr_clr", overrun, 1'b0);

    // push and pop together on a full FIFO
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b0);
      exp_q.push_back({1'b0, 8'(i)});
    end
    check("full_count", count, 4);
    fork
      send_frame(8'h05, 1'b0);
      pop_on_drain();
    join
    exp_q.push_back({1'b0, 8'h05});
    check("full_pp_count", count, 4);
    check("full_pp_overrun", overrun, 1'b0);
    for (int i = 0; i < 4; i++) pop_one("full_pp_pop");

    // reset in the middle of a frame
    send_frame(8'h66, 1'b0);
    check("mid_pre_count", count, 1);
    fork
      send_frame(8'h99, 1'b0);
      begin
        repeat (60) @(negedge clk);
        check("mid_in_frame", state_dbg, 2'd2);
        resetN = 1'b0;
        @(negedge clk);
        check("mid_rst_rx_en", rx_en, 1'b0);
        check("mid_rst_count", count, 0);
        check("mid_rst_state", state_dbg, S_IDLE);
        check("mid_rst_valid", pop_if.out_valid, 1'b0);
      end
    join
    exp_q.delete();
    repeat (5) @(negedge clk);
    resetN = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_post_count", count, 0);
    send_frame(8'h3C, 1'b0);
    exp_q.push_back({1'b0, 8'h3C});
    check("mid_next_count", count, 1);
    pop_one("mid_next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
